// File: rtl/aes_pkg.sv
// aes_pkg
// Shared constants and types for the AES-128 blocks.
//   AES_KEY_W   : width of an AES-128 key / round key (128)
//   NUM_ROUNDS  : number of round keys generated after round key 0 (10)
//   RCON_TABLE  : round constants Rcon[1..10], packed MSB-first (Rcon[1] in [79:72])
//   ks_state_e  : key-scheduler FSM states
//   rcon_lookup : Rcon byte for counter 1..10, 8'h00 for any other value
//   rot_word    : FIPS-197 RotWord (cyclic left rotate by one byte)
package aes_pkg;

  localparam int AES_KEY_W  = 128;
  localparam int NUM_ROUNDS = 10;

  localparam logic [8*NUM_ROUNDS-1:0] RCON_TABLE = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } ks_state_e;

  // Only counter values 1..10 select a table entry; anything else yields zero
  // so an out-of-range counter can never pick up a stray constant.
  function automatic logic [7:0] rcon_lookup(input logic [3:0] ctr);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 1; i <= NUM_ROUNDS; i++) begin
      if (ctr == 4'(i)) r = RCON_TABLE[(NUM_ROUNDS - i) * 8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox
// Combinational AES forward S-box (FIPS-197 SubBytes for one byte).
// Shared by the key scheduler (SubWord) and the encryption datapath.
// Ports:
//   byte_in  : input byte
//   byte_out : substituted byte
module aes_sbox (
  input  logic [7:0] byte_in,
  output logic [7:0] byte_out
);

  // Row 0 of the standard table sits in the top bits, so entry x lives at
  // bit offset (255 - x) * 8, which is just the bitwise inverse of x times 8.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign byte_out = SBOX_TABLE[{~byte_in, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_scheduler.sv
// aes_key_scheduler
// AES-128 key expansion: latches a cipher key, then generates round keys
// 1..10 one per clock into a register array that the encryption stage reads
// back by address.
// Ports:
//   clk            : clock, all state changes on the rising edge
//   rst            : synchronous active-high reset
//   key_in         : cipher key, captured only on an accepted key_load
//   key_load       : one-cycle request to start an expansion (ignored while expanding)
//   key_clear      : zeroize request (only with AES_KEY_ZEROIZE_EN defined)
//   round_key_addr : round-key select, addr k returns round key k+1
//   round_key_0    : latched cipher key (initial AddRoundKey)
//   round_key_input: registered round key for round_key_addr, 1-cycle latency
//   key_busy       : expansion in progress
//   keys_ready     : all 10 round keys valid
// Configuration:
//   AES_KEY_ZEROIZE_EN : adds key_clear; zeroes all key material and returns to IDLE.
module aes_key_scheduler #(
  parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [aes_pkg::AES_KEY_W-1:0] key_in,
  input  logic                         key_load,
`ifdef AES_KEY_ZEROIZE_EN
  input  logic                         key_clear,
`endif
  input  logic [3:0]                   round_key_addr,
  output logic [aes_pkg::AES_KEY_W-1:0] round_key_0,
  output logic [aes_pkg::AES_KEY_W-1:0] round_key_input,
  output logic                         key_busy,
  output logic                         keys_ready
);

  import aes_pkg::*;

  ks_state_e               state;
  ks_state_e               state_next;
  logic [3:0]              ctr;
  logic [AES_KEY_W-1:0]    round_keys [NUM_ROUNDS];
  logic [AES_KEY_W-1:0]    prev_key;
  logic [AES_KEY_W-1:0]    next_key;
  logic [AES_KEY_W-1:0]    read_key;
  logic [31:0]             sub_in;
  logic [31:0]             sub_out;
  logic [31:0]             temp_word;
  logic [31:0]             w0_next;
  logic [31:0]             w1_next;
  logic [31:0]             w2_next;
  logic [31:0]             w3_next;
  logic                    clear_req;

`ifdef AES_KEY_ZEROIZE_EN
  assign clear_req = key_clear;
`else
  assign clear_req = 1'b0;
`endif

  assign key_busy   = (state == EXPAND);
  assign keys_ready = (state == READY);

  // Round key ctr is derived from round key ctr-1: the cipher key for ctr=1,
  // otherwise the array slot written on the previous expansion cycle.
  always_comb begin
    prev_key = round_key_0;
    for (int i = 0; i < NUM_ROUNDS - 1; i++) begin
      if (ctr == 4'(i + 2)) prev_key = round_keys[i];
    end
  end

  assign sub_in = rot_word(prev_key[31:0]);

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .byte_in  (sub_in[8*g +: 8]),
      .byte_out (sub_out[8*g +: 8])
    );
  end

  // Words are big-endian: w0 is [127:96], and each new word chains off the
  // one just produced.
  always_comb begin
    temp_word = sub_out ^ {rcon_lookup(ctr), 24'h000000};
    w0_next   = prev_key[127:96] ^ temp_word;
    w1_next   = prev_key[95:64]  ^ w0_next;
    w2_next   = prev_key[63:32]  ^ w1_next;
    w3_next   = prev_key[31:0]   ^ w2_next;
    next_key  = {w0_next, w1_next, w2_next, w3_next};
  end

  // Read mux; addresses 10..15 fall through to zero.
  always_comb begin
    read_key = '0;
    for (int i = 0; i < NUM_ROUNDS; i++) begin
      if (round_key_addr == 4'(i)) read_key = round_keys[i];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: zeroize beats load, and load is only honoured outside EXPAND.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, READY: begin
        if (clear_req)     state_next = IDLE;
        else if (key_load) state_next = EXPAND;
      end
      EXPAND: begin
        if (clear_req)                        state_next = IDLE;
        else if (ctr == 4'(NUM_ROUNDS))       state_next = READY;
      end
      default: state_next = IDLE;
    endcase
  end

  // Key storage, round counter and the registered read port.  A new load in
  // READY leaves the old array contents in place; they are unreachable because
  // reads return zero until keys_ready is set again.
  always_ff @(posedge clk) begin
    if (rst || clear_req) begin
      round_key_0     <= '0;
      round_key_input <= '0;
      ctr             <= 4'd0;
      for (int i = 0; i < NUM_ROUNDS; i++) round_keys[i] <= '0;
    end else begin
      if (state != EXPAND && key_load) begin
        round_key_0 <= key_in;
        ctr         <= 4'd1;
      end else if (state == EXPAND) begin
        for (int i = 0; i < NUM_ROUNDS; i++) begin
          if (ctr == 4'(i + 1)) round_keys[i] <= next_key;
        end
        if (ctr < 4'(NUM_ROUNDS)) ctr <= ctr + 4'd1;
      end

      if (state == READY) round_key_input <= read_key;
      else                round_key_input <= '0;
    end
  end

endmodule
